// File: rtl/register_bank.sv
// register_bank: multi-entry register file with one byte-masked write port,
// READ_PORTS asynchronous read ports, optional write-to-read bypass, optional
// hardwired-zero entry 0 and a per-entry busy scoreboard for RAW detection.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high; entries <= INITIAL, busy <= 0
//   write_enable   commit a write this cycle (also clears busy of write_addr)
//   write_addr     entry written
//   write_byte_en  per-byte write mask, bit i covers data[8i+7:8i]
//   write_data     write value
//   mark_busy      set busy bit of mark_addr at the edge
//   mark_addr      entry to mark busy
//   read_addr      packed read addresses, port p in slice p
//   read_data      packed read data, port p in slice p (combinational)
//   read_busy      per-port pending-write flag of the addressed entry
//   busy_count     registered popcount of the busy bits
module register_bank #(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     DEPTH      = 32,
  parameter int unsigned     READ_PORTS = 2,
  parameter int unsigned     ZERO_REG   = 1,
  parameter int unsigned     BYPASS     = 1,
  parameter logic [WIDTH-1:0] INITIAL   = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             write_enable,
  input  logic [$clog2(DEPTH)-1:0]         write_addr,
  input  logic [WIDTH/8-1:0]               write_byte_en,
  input  logic [WIDTH-1:0]                 write_data,
  input  logic                             mark_busy,
  input  logic [$clog2(DEPTH)-1:0]         mark_addr,
  input  logic [READ_PORTS*$clog2(DEPTH)-1:0] read_addr,
  output logic [READ_PORTS*WIDTH-1:0]      read_data,
  output logic [READ_PORTS-1:0]            read_busy,
  output logic [$clog2(DEPTH):0]           busy_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] write_merged;
  logic             write_allowed;

  // Entry 0 is read-only when hardwired to zero.
  assign write_allowed = write_enable && !((ZERO_REG != 0) && (write_addr == '0));

  // Value the written entry will hold after the edge: enabled bytes from
  // write_data, the rest from the current contents.
  always_comb begin
    write_merged = mem[write_addr];
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (write_byte_en[b]) begin
        write_merged[8*b +: 8] = write_data[8*b +: 8];
      end
    end
  end

  // Mark is applied after the clear so a same-address write+mark leaves the
  // entry busy (the newer producer owns it).
  always_comb begin
    busy_next = busy;
    if (write_enable) begin
      busy_next[write_addr] = 1'b0;
    end
    if (mark_busy) begin
      busy_next[mark_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
    count_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{AW{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= INITIAL;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (write_allowed) begin
        mem[write_addr] <= write_merged;
      end
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      if ((ZERO_REG != 0) && (read_addr[p*AW +: AW] == '0)) begin
        read_data[p*WIDTH +: WIDTH] = '0;
        read_busy[p]                = 1'b0;
      end else if ((BYPASS != 0) && write_enable && (read_addr[p*AW +: AW] == write_addr)) begin
        read_data[p*WIDTH +: WIDTH] = write_merged;
        read_busy[p]                = busy_next[read_addr[p*AW +: AW]];
      end else begin
        read_data[p*WIDTH +: WIDTH] = mem[read_addr[p*AW +: AW]];
        read_busy[p]                = busy[read_addr[p*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank. Two instances share all inputs:
// dut (BYPASS=1, ZERO_REG=1, INITIAL=0) and dut_nb (BYPASS=0, ZERO_REG=0,
// nonzero INITIAL). A behavioural array model predicts every output.
module tb_register_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        mk;
  logic [4:0]  ma;
  logic [9:0]  ra;
  logic [63:0] rd0, rd1;
  logic [1:0]  rb0, rb1;
  logic [5:0]  bc0, bc1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] INIT_NB = 32'hA5A5_5A5A;

  always #5 clock = ~clock;

  register_bank #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(1),
                  .BYPASS(1), .INITIAL(32'h0)) dut (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa),
    .write_byte_en(be), .write_data(wd), .mark_busy(mk), .mark_addr(ma),
    .read_addr(ra), .read_data(rd0), .read_busy(rb0), .busy_count(bc0));

  register_bank #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(0),
                  .BYPASS(0), .INITIAL(INIT_NB)) dut_nb (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa),
    .write_byte_en(be), .write_data(wd), .mark_busy(mk), .mark_addr(ma),
    .read_addr(ra), .read_data(rd1), .read_busy(rb1), .busy_count(bc1));

  // Reference model: per-instance contents and busy flags.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  bit          cfg_zero [2] = '{1'b1, 1'b0};
  bit          cfg_byp  [2] = '{1'b1, 1'b0};
  logic [31:0] cfg_init [2] = '{32'h0, INIT_NB};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merged(input int inst);
    logic [31:0] v = m_mem[inst][wa];
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32; a++) begin
        m_mem[i][a]  = cfg_init[i];
        m_busy[i][a] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (we && !(cfg_zero[i] && wa == 0)) m_mem[i][wa] = merged(i);
      if (we) m_busy[i][wa] = 1'b0;
      if (mk && !(cfg_zero[i] && ma == 0)) m_busy[i][ma] = 1'b1;
    end
  endtask

  task automatic compare();
    logic [4:0]  a;
    logic [31:0] ed;
    logic        eb;
    int          cnt;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        a = ra[p*5 +: 5];
        if (cfg_zero[i] && a == 0) begin
          ed = 32'h0; eb = 1'b0;
        end else if (cfg_byp[i] && we && a == wa) begin
          ed = merged(i); eb = mk && (ma == a);
        end else begin
          ed = m_mem[i][a]; eb = m_busy[i][a];
        end
        check($sformatf("inst%0d_p%0d_data_a%0d", i, p, a),
              (i == 0) ? rd0[p*32 +: 32] : rd1[p*32 +: 32], ed);
        check($sformatf("inst%0d_p%0d_busy_a%0d", i, p, a),
              {31'b0, (i == 0) ? rb0[p] : rb1[p]}, {31'b0, eb});
      end
      cnt = 0;
      for (int k = 0; k < 32; k++) cnt += int'(m_busy[i][k]);
      check($sformatf("inst%0d_busy_count", i),
            {26'b0, (i == 0) ? bc0 : bc1}, cnt);
    end
  endtask

  // Inputs are set just after a rising edge; compare on the falling edge,
  // then advance the model across the next rising edge.
  task automatic cycle();
    @(negedge clock);
    compare();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; mk = 1'b0; be = 4'h0; wd = '0; wa = '0; ma = '0;
  endtask

  initial begin
    idle();
    ra = '0;
    reset = 1'b1;
    @(posedge clock);
    model_reset();
    #1;
    reset = 1'b0;

    // Every entry after reset, both ports.
    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      cycle();
    end

    // Full write then byte-masked overwrite of entry 5.
    we = 1'b1; wa = 5'd5; be = 4'hF; wd = 32'hDEAD_BEEF; ra = {5'd5, 5'd5};
    cycle();
    be = 4'b0101; wd = 32'h1122_3344;
    cycle();
    idle();
    #1;
    check("entry5_merge", rd0[31:0], 32'hDE22_BE44);
    cycle();

    // Same-cycle write and read of entry 7 on port 1.
    we = 1'b1; wa = 5'd7; be = 4'hF; wd = 32'hCAFE_F00D; ra = {5'd7, 5'd2};
    #1;
    check("bypass_p1", rd0[63:32], 32'hCAFE_F00D);
    check("nobypass_p1", rd1[63:32], INIT_NB);
    cycle();
    idle();
    cycle();

    // Busy scoreboard on entry 3.
    mk = 1'b1; ma = 5'd3; ra = {5'd3, 5'd3};
    cycle();
    idle();
    #1;
    check("mark3_count", {26'b0, bc0}, 32'd1);
    cycle();
    we = 1'b1; wa = 5'd3; be = 4'hF; wd = 32'h0BAD_F00D;
    cycle();
    idle();
    cycle();
    we = 1'b1; wa = 5'd3; be = 4'hF; wd = 32'h1357_9BDF; mk = 1'b1; ma = 5'd3;
    cycle();
    idle();
    #1;
    check("wr_mark3_busy", {31'b0, rb0[0]}, 32'd1);
    cycle();

    // Entry 0 write and mark (discarded on the zero-register instance).
    we = 1'b1; wa = 5'd0; be = 4'hF; wd = 32'hFFFF_FFFF; mk = 1'b1; ma = 5'd0;
    ra = {5'd3, 5'd0};
    cycle();
    idle();
    cycle();

    // Mark 1..31, then reset together with a write to entry 9.
    for (int a = 1; a < 32; a++) begin
      mk = 1'b1; ma = 5'(a); ra = {5'(a), 5'd9};
      cycle();
    end
    idle();
    #1;
    check("all_marked_count", {26'b0, bc0}, 32'd31);
    reset = 1'b1; we = 1'b1; wa = 5'd9; be = 4'hF; wd = 32'h7777_7777; mk = 1'b1; ma = 5'd4;
    cycle();
    idle();
    #1;
    check("reset_count", {26'b0, bc0}, 32'd0);
    check("reset_entry9", rd1[31:0], INIT_NB);
    cycle();

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      we    = $urandom_range(0, 1);
      wa    = 5'($urandom_range(0, 31));
      be    = 4'($urandom);
      wd    = $urandom;
      mk    = $urandom_range(0, 1);
      ma    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra[4:0] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra[9:5] = ($urandom_range(0, 2) == 0) ? ma : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Multi-entry, multi-read-port generalisation of the single-entry register, for the rvsimple core's integer register file and for CSR-shadow banks.
- One write port with byte enables.
- Parametrised count of asynchronous read ports, optional write-to-read bypass, optional hardwired-zero entry 0.
- Per-entry busy scoreboard so pipelined datapaths can detect pending writes (RAW hazards).

Parameters:
WIDTH, 32, data bits per entry; must be a multiple of 8
DEPTH, 32, number of entries; power of two, >= 2
READ_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
INITIAL, 0, reset value of every entry

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clock clock
write_enable  input  1  commit write this cycle
write_addr  input  $clog2(DEPTH)  entry written
write_byte_en  input  WIDTH/8  per-byte write mask; bit i covers data[8i+7:8i]
write_data  input  WIDTH  write value
mark_busy  input  1  set busy bit of mark_addr (instruction issued with that destination)
mark_addr  input  $clog2(DEPTH)  entry to mark busy
read_addr  input  READ_PORTS*$clog2(DEPTH)  packed read addresses; port p in slice p
read_data  output  READ_PORTS*WIDTH  packed read data; port p in slice p
read_busy  output  READ_PORTS  1 = addressed entry has a pending write
busy_count  output  $clog2(DEPTH)+1  number of entries currently busy

Behaviour:
- Reset, sync: every entry <= INITIAL, all busy bits <= 0.
  - Outputs combinational from state: after the reset edge, read_data = INITIAL (0 for entry 0 when ZERO_REG), read_busy = 0, busy_count = 0.
  - Reset overrides write_enable and mark_busy in the same cycle.
- Write, 1-cycle latency: on the rising edge with write_enable=1, bytes with write_byte_en[i]=1 take write_data; other bytes hold.
  - write_byte_en = 0 with write_enable = 1 changes no data but still clears busy.
- Busy clear: a write (write_enable=1) to entry a clears busy[a] at the same edge.
- Busy set: mark_busy=1 sets busy[mark_addr] at the edge.
- Simultaneous write and mark to the same address: mark wins, busy stays 1 (the newer producer owns the entry). Data is still written.
- Marking an already-busy entry: busy stays 1. busy_count never double-counts.
- busy_count = popcount of busy bits; registered alongside the busy bits.
- Read: combinational from read_addr (zero-cycle latency).
- Bypass, BYPASS=1: if write_enable=1 and read_addr[p]==write_addr, read_data[p] is the merge of write_data (enabled bytes) and stored data (other bytes).
  - read_busy[p] then shows the post-edge value: 0 unless mark_busy targets the same address.
  - BYPASS=0: reads return stored contents and current busy bits only.
- ZERO_REG=1:
  - Writes to entry 0 are discarded.
  - mark_busy to entry 0 is ignored.
  - Reads of entry 0 return 0 and read_busy=0, including under bypass.
- Read ports are fully independent. Any number may address the same entry.
- Address width: out-of-range addresses are not possible (DEPTH is a power of two). No wrap-around logic.
- Reset asserted mid-operation discards any write in that cycle. Pending busy state is lost by design; the pipeline flushes on reset.

Test Plan:
- Reset with INITIAL=32'h0000_0000, then read all 32 entries on both ports -> every read_data = 0, read_busy = 0, busy_count = 0.
- Write entry 5 = 32'hDEAD_BEEF (byte_en=4'hF), next cycle write entry 5 = 32'h1122_3344 with byte_en=4'b0101 -> entry 5 reads 32'hDE22_BE44.
- BYPASS=1: same cycle write entry 7 = 32'hCAFE_F00D, port 1 read_addr=7 -> read_data[1] = 32'hCAFE_F00D before the edge. Repeat with BYPASS=0 -> old value until after the edge.
- mark_busy entry 3 -> busy_count=1, read_busy=1 on ports reading 3. Write entry 3 -> busy clears, count=0. Write and mark entry 3 in the same cycle -> busy stays 1, data updated.
- ZERO_REG=1: write entry 0 = 32'hFFFF_FFFF and mark_busy 0 -> entry 0 reads 0, read_busy=0, busy_count unchanged.
- Mark entries 1..31 over 31 cycles, assert reset together with a write to entry 9 -> busy_count=0 and entry 9 = INITIAL after the edge.
